// File: rtl/muldiv_sequencer_pkg.sv
// Shared ALU control codes and muldiv sequencer state encoding.
// Exports OP* codes, mds_state_e and op-class decode helpers.
package muldiv_sequencer_pkg;

  localparam logic [4:0] OPADD    = 5'b00010;
  localparam logic [4:0] OPMUL    = 5'b10000;
  localparam logic [4:0] OPMULH   = 5'b10001;
  localparam logic [4:0] OPMULHSU = 5'b10010;
  localparam logic [4:0] OPMULHU  = 5'b10011;
  localparam logic [4:0] OPDIV    = 5'b10100;
  localparam logic [4:0] OPDIVU   = 5'b10101;
  localparam logic [4:0] OPREM    = 5'b10110;
  localparam logic [4:0] OPREMU   = 5'b10111;

  typedef enum logic [1:0] {
    MDS_IDLE  = 2'd0,
    MDS_CALC  = 2'd1,
    MDS_FIXUP = 2'd2,
    MDS_DONE  = 2'd3
  } mds_state_e;

  function automatic logic op_is_md(input logic [4:0] op);
    return op[4:3] == 2'b10;
  endfunction

  function automatic logic op_is_div(input logic [4:0] op);
    return (op == OPDIV) || (op == OPDIVU) ||
           (op == OPREM) || (op == OPREMU);
  endfunction

  function automatic logic op_is_rem(input logic [4:0] op);
    return (op == OPREM) || (op == OPREMU);
  endfunction

  function automatic logic op_signed_a(input logic [4:0] op);
    return (op == OPMULH) || (op == OPMULHSU) ||
           (op == OPDIV) || (op == OPREM);
  endfunction

  function automatic logic op_signed_b(input logic [4:0] op);
    return (op == OPMULH) || (op == OPDIV) || (op == OPREM);
  endfunction

endpackage

// File: rtl/muldiv_core.sv
// Radix-2 iteration datapath: shift-add multiply / restoring divide on magnitudes.
// Ports: clk, rst, load (acc_init/opnd/is_div), step (one iteration), acc out.
module muldiv_core
  import muldiv_sequencer_pkg::*;
#(
  parameter int WIDTH = 64
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               load,
  input  logic               step,
  input  logic               is_div,
  input  logic [2*WIDTH-1:0] acc_init,
  input  logic [WIDTH-1:0]   opnd,
  output logic [2*WIDTH-1:0] acc
);

  logic [2*WIDTH-1:0] acc_q, acc_d;
  logic [WIDTH-1:0]   opnd_q, opnd_d;
  logic               div_q, div_d;
  logic [WIDTH:0]     add_sum;
  logic [WIDTH:0]     shl;
  logic [WIDTH-1:0]   dif;
  logic               ge;

  always_comb begin
    acc_d   = acc_q;
    opnd_d  = opnd_q;
    div_d   = div_q;
    // mul: hi half accumulates, lo half shifts multiplier out
    add_sum = {1'b0, acc_q[2*WIDTH-1:WIDTH]} +
              (acc_q[0] ? {1'b0, opnd_q} : '0);
    // div: hi half is partial remainder, lo half dividend -> quotient
    shl     = {acc_q[2*WIDTH-1:WIDTH], acc_q[WIDTH-1]};
    ge      = shl >= {1'b0, opnd_q};
    dif     = shl[WIDTH-1:0] - opnd_q;
    if (load) begin
      acc_d  = acc_init;
      opnd_d = opnd;
      div_d  = is_div;
    end else if (step) begin
      if (div_q) begin
        acc_d = ge ? {dif, acc_q[WIDTH-2:0], 1'b1}
                   : {shl[WIDTH-1:0], acc_q[WIDTH-2:0], 1'b0};
      end else begin
        acc_d = {add_sum, acc_q[WIDTH-1:1]};
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      acc_q  <= '0;
      opnd_q <= '0;
      div_q  <= 1'b0;
    end else begin
      acc_q  <= acc_d;
      opnd_q <= opnd_d;
      div_q  <= div_d;
    end
  end

  assign acc = acc_q;

endmodule

// File: rtl/muldiv_sequencer.sv
// Iterative mul/div unit with start/ready/done handshake, kill and sign fixup.
// Ports: iCLK iRST iStart iKill iALUControl iA iB -> oReady oDone oResult oIllegal.
// Option: MULDIV_EARLY_OUT_EN skips CALC for A=0, B=0 or MUL* with B=1.
module muldiv_sequencer
  import muldiv_sequencer_pkg::*;
#(
  parameter int WIDTH = 64,
  parameter int CNTW  = 7
) (
  input  logic             iCLK,
  input  logic             iRST,
  input  logic             iStart,
  input  logic             iKill,
  input  logic [4:0]       iALUControl,
  input  logic [WIDTH-1:0] iA,
  input  logic [WIDTH-1:0] iB,
  output logic             oReady,
  output logic             oDone,
  output logic [WIDTH-1:0] oResult,
  output logic             oIllegal
);

  mds_state_e         state_q, state_d;
  logic [CNTW-1:0]    cnt_q, cnt_d;
  logic [4:0]         op_q, op_d;
  logic               neg_q, neg_d;
  logic               bz_q, bz_d;
  logic               ill_q, ill_d;
  logic [WIDTH-1:0]   araw_q, araw_d;
  logic [WIDTH-1:0]   res_q, res_d;

  logic               a_neg, b_neg, is_div_in, eo_in;
  logic               load, step;
  logic [WIDTH-1:0]   a_mag, b_mag, opnd_in;
  logic [2*WIDTH-1:0] acc_init, acc, prod;
  logic [WIDTH-1:0]   quo, rem, fix_res;

  muldiv_core #(.WIDTH(WIDTH)) u_core (
    .clk      (iCLK),
    .rst      (iRST),
    .load     (load),
    .step     (step),
    .is_div   (is_div_in),
    .acc_init (acc_init),
    .opnd     (opnd_in),
    .acc      (acc)
  );

  always_comb begin
    a_neg     = op_signed_a(iALUControl) & iA[WIDTH-1];
    b_neg     = op_signed_b(iALUControl) & iB[WIDTH-1];
    a_mag     = a_neg ? -iA : iA;
    b_mag     = b_neg ? -iB : iB;
    is_div_in = op_is_div(iALUControl);
    opnd_in   = is_div_in ? b_mag : a_mag;
    acc_init  = is_div_in ? {{WIDTH{1'b0}}, a_mag}
                          : {{WIDTH{1'b0}}, b_mag};
`ifdef MULDIV_EARLY_OUT_EN
    // preload the finished magnitude so FIXUP sees the full-path value
    eo_in = (iA == '0) || (iB == '0) ||
            (!is_div_in && (iB == WIDTH'(1)));
    if (!is_div_in && (iA == '0))
      acc_init = '0;
    else if (!is_div_in && (iB == WIDTH'(1)))
      acc_init = {{WIDTH{1'b0}}, a_mag};
`else
    eo_in = 1'b0;
`endif
  end

  always_comb begin
    prod    = neg_q ? -acc : acc;
    quo     = neg_q ? -acc[WIDTH-1:0] : acc[WIDTH-1:0];
    rem     = neg_q ? -acc[2*WIDTH-1:WIDTH]
                    : acc[2*WIDTH-1:WIDTH];
    fix_res = '0;
    unique case (1'b1)
      op_q == OPMUL:
        fix_res = prod[WIDTH-1:0];
      op_q == OPMULH, op_q == OPMULHU, op_q == OPMULHSU:
        fix_res = prod[2*WIDTH-1:WIDTH];
      op_is_rem(op_q):
        fix_res = bz_q ? araw_q : rem;
      default:
        fix_res = bz_q ? '0 : quo;
    endcase
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    op_d    = op_q;
    neg_d   = neg_q;
    bz_d    = bz_q;
    ill_d   = ill_q;
    araw_d  = araw_q;
    res_d   = res_q;
    load    = 1'b0;
    step    = 1'b0;
    unique case (state_q)
      MDS_IDLE, MDS_DONE: begin
        if (iStart) begin
          op_d   = iALUControl;
          neg_d  = op_is_rem(iALUControl) ? a_neg : (a_neg ^ b_neg);
          bz_d   = (iB == '0);
          araw_d = iA;
          cnt_d  = '0;
          if (op_is_md(iALUControl)) begin
            ill_d   = 1'b0;
            load    = 1'b1;
            state_d = eo_in ? MDS_FIXUP : MDS_CALC;
          end else begin
            ill_d   = 1'b1;
            res_d   = '0;
            state_d = MDS_DONE;
          end
        end else begin
          state_d = MDS_IDLE;
        end
      end
      MDS_CALC: begin
        if (iKill) begin
          state_d = MDS_IDLE;
        end else begin
          step  = 1'b1;
          cnt_d = cnt_q + CNTW'(1);
          if (cnt_q == CNTW'(WIDTH - 1))
            state_d = MDS_FIXUP;
        end
      end
      MDS_FIXUP: begin
        if (iKill) begin
          state_d = MDS_IDLE;
        end else begin
          res_d   = fix_res;
          state_d = MDS_DONE;
        end
      end
      default: state_d = MDS_IDLE;
    endcase
  end

  always_ff @(posedge iCLK) begin
    if (iRST) begin
      state_q <= MDS_IDLE;
      cnt_q   <= '0;
      op_q    <= '0;
      neg_q   <= 1'b0;
      bz_q    <= 1'b0;
      ill_q   <= 1'b0;
      araw_q  <= '0;
      res_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      op_q    <= op_d;
      neg_q   <= neg_d;
      bz_q    <= bz_d;
      ill_q   <= ill_d;
      araw_q  <= araw_d;
      res_q   <= res_d;
    end
  end

  assign oReady   = (state_q == MDS_IDLE) || (state_q == MDS_DONE);
  assign oDone    = (state_q == MDS_DONE);
  assign oResult  = res_q;
  assign oIllegal = oDone & ill_q;

endmodule

// File: tb/tb_muldiv_sequencer.sv
// Bench for muldiv_sequencer: arithmetic reference model + per-cycle compare.
// Directed vectors with literal expectations; honours MULDIV_EARLY_OUT_EN.
module tb_muldiv_sequencer;
  import muldiv_sequencer_pkg::*;

  localparam logic [63:0] MIN = 64'h8000000000000000;
  localparam logic [63:0] M1  = 64'hFFFFFFFFFFFFFFFF;
`ifdef MULDIV_EARLY_OUT_EN
  localparam int LZ = 2;
`else
  localparam int LZ = 66;
`endif

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start = 1'b0;
  logic        kill = 1'b0;
  logic [4:0]  alu = '0;
  logic [63:0] ia = '0;
  logic [63:0] ib = '0;
  logic        o_ready, o_done, o_ill;
  logic [63:0] o_res;

  int n_tests = 0;
  int n_fail  = 0;
  bit chk_en  = 0;

  muldiv_sequencer dut (
    .iCLK        (clk),
    .iRST        (rst),
    .iStart      (start),
    .iKill       (kill),
    .iALUControl (alu),
    .iA          (ia),
    .iB          (ib),
    .oReady      (o_ready),
    .oDone       (o_done),
    .oResult     (o_res),
    .oIllegal    (o_ill)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [63:0] act,
                     input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h want %h", nm, act, exp);
    end
  endtask

  // {illegal, result} from plain arithmetic
  function automatic logic [64:0] ref_op(input logic [4:0] op,
                                         input logic [63:0] a,
                                         input logic [63:0] b);
    logic [127:0]       p;
    logic signed [63:0] sa, sb, q;
    sa = a;
    sb = b;
    p  = '0;
    q  = '0;
    case (op)
      OPMUL:    return {1'b0, a * b};
      OPMULH: begin
        p = {{64{a[63]}}, a} * {{64{b[63]}}, b};
        return {1'b0, p[127:64]};
      end
      OPMULHU: begin
        p = {64'd0, a} * {64'd0, b};
        return {1'b0, p[127:64]};
      end
      OPMULHSU: begin
        p = {{64{a[63]}}, a} * {64'd0, b};
        return {1'b0, p[127:64]};
      end
      OPDIV: begin
        if (b == 0) return '0;
        if (a == MIN && b == M1) return {1'b0, a};
        q = sa / sb;
        return {1'b0, q};
      end
      OPREM: begin
        if (b == 0) return {1'b0, a};
        if (a == MIN && b == M1) return '0;
        q = sa % sb;
        return {1'b0, q};
      end
      OPDIVU:   return (b == 0) ? 65'd0 : {1'b0, a / b};
      OPREMU:   return (b == 0) ? {1'b0, a} : {1'b0, a % b};
      default:  return {1'b1, 64'd0};
    endcase
  endfunction

  function automatic int lat_edges(input logic [4:0] op,
                                   input logic [63:0] a,
                                   input logic [63:0] b);
`ifdef MULDIV_EARLY_OUT_EN
    bit is_mul;
    is_mul = (op == OPMUL) || (op == OPMULH) ||
             (op == OPMULHU) || (op == OPMULHSU);
    if (a == 0 || b == 0 || (is_mul && b == 1)) return 2;
`endif
    return (op == 5'd0) ? 66 : 66;
  endfunction

  // model: edges left until done, current result and flags
  int          m_left = 0;
  bit          m_done = 0;
  bit          m_ill  = 0;
  logic [63:0] m_res  = '0;
  logic [63:0] m_pend = '0;
  logic [64:0] m_r;

  always @(posedge clk) begin
    if (rst) begin
      m_left = 0;
      m_done = 0;
      m_ill  = 0;
      m_res  = '0;
    end else if (m_left > 0) begin
      if (kill) begin
        m_left = 0;
      end else begin
        m_left--;
        if (m_left == 0) begin
          m_done = 1;
          m_res  = m_pend;
        end
      end
    end else begin
      m_done = 0;
      m_ill  = 0;
      if (start) begin
        m_r = ref_op(alu, ia, ib);
        if (m_r[64]) begin
          m_done = 1;
          m_ill  = 1;
          m_res  = '0;
        end else begin
          m_pend = m_r[63:0];
          m_left = lat_edges(alu, ia, ib) - 1;
        end
      end
    end
  end

  always @(negedge clk) begin
    if (chk_en) begin
      chk("cyc_ready", o_ready, m_left == 0);
      chk("cyc_done", o_done, m_done);
      chk("cyc_ill", o_ill, m_done & m_ill);
      chk("cyc_res", o_res, m_res);
    end
  end

  task automatic start_op(input logic [4:0] op, input logic [63:0] a,
                          input logic [63:0] b);
    @(negedge clk);
    start = 1'b1;
    alu   = op;
    ia    = a;
    ib    = b;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic wait_done(input int n0, output int n);
    n = n0;
    while (!o_done && n < 300) begin
      @(negedge clk);
      n++;
    end
  endtask

  task automatic run_op(input string nm, input logic [4:0] op,
                        input logic [63:0] a, input logic [63:0] b,
                        input logic [63:0] exp, input logic exp_ill,
                        input int exp_n);
    int n;
    start_op(op, a, b);
    wait_done(1, n);
    chk({nm, "_res"}, o_res, exp);
    chk({nm, "_ill"}, o_ill, exp_ill);
    chk({nm, "_lat"}, n, exp_n);
    @(negedge clk);
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int  n;
    bit  seen;
    repeat (2) @(negedge clk);
    chk_en = 1;
    chk("rst_ready", o_ready, 1);
    chk("rst_done", o_done, 0);
    chk("rst_res", o_res, 0);
    rst = 1'b0;

    run_op("mul", OPMUL, 64'd7, -64'sd3, 64'hFFFFFFFFFFFFFFEB, 0, 66);
    run_op("mulhu", OPMULHU, M1, M1, 64'hFFFFFFFFFFFFFFFE, 0, 66);
    run_op("mulh", OPMULH, M1, M1, 64'd0, 0, 66);
    run_op("mulhsu", OPMULHSU, 64'd2, M1, 64'd1, 0, 66);
    run_op("div", OPDIV, -64'sd7, 64'd2, 64'hFFFFFFFFFFFFFFFD, 0, 66);
    run_op("rem", OPREM, -64'sd7, 64'd2, M1, 0, 66);
    run_op("divu", OPDIVU, 64'd100, 64'd7, 64'd14, 0, 66);
    run_op("remu", OPREMU, 64'd100, 64'd7, 64'd2, 0, 66);
    run_op("div0", OPDIV, 64'd5, 64'd0, 64'd0, 0, LZ);
    run_op("rem0", OPREM, 64'd5, 64'd0, 64'd5, 0, LZ);
    run_op("divovf", OPDIV, MIN, M1, MIN, 0, 66);
    run_op("removf", OPREM, MIN, M1, 64'd0, 0, 66);
    run_op("mul1", OPMUL, 64'h123, 64'd1, 64'h123, 0, LZ);
    run_op("illegal", OPADD, 64'd9, 64'd9, 64'd0, 1, 1);

    // second start while busy is dropped
    start_op(OPMUL, 64'd6, 64'd7);
    repeat (4) @(negedge clk);
    start = 1'b1;
    alu   = OPADD;
    repeat (6) @(negedge clk);
    start = 1'b0;
    wait_done(11, n);
    chk("busy_res", o_res, 64'd42);
    chk("busy_lat", n, 66);
    @(negedge clk);

    // start held through DONE is taken back-to-back
    start_op(OPDIVU, 64'd100, 64'd7);
    wait_done(1, n);
    chk("b2b_first", o_res, 64'd14);
    start = 1'b1;
    alu   = OPREMU;
    @(negedge clk);
    start = 1'b0;
    chk("b2b_busy", o_ready, 0);
    wait_done(1, n);
    chk("b2b_res", o_res, 64'd2);
    chk("b2b_lat", n, 66);
    @(negedge clk);

    // kill at iteration 30
    start_op(OPMUL, 64'd3, 64'd5);
    repeat (29) @(negedge clk);
    kill = 1'b1;
    @(negedge clk);
    kill = 1'b0;
    chk("kill_ready", o_ready, 1);
    chk("kill_res", o_res, 64'd2);
    seen = 0;
    repeat (70) begin
      @(negedge clk);
      if (o_done) seen = 1;
    end
    chk("kill_nodone", seen, 0);

    // reset at iteration 10
    start_op(OPDIVU, 64'd100, 64'd7);
    repeat (9) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("mrst_ready", o_ready, 1);
    chk("mrst_done", o_done, 0);
    chk("mrst_res", o_res, 0);
    chk("mrst_ill", o_ill, 0);

    run_op("after", OPMUL, -64'sd4, -64'sd5, 64'd20, 0, 66);
    repeat (3) @(negedge clk);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
